cache_mem_arbiter: RTL and testbench

- Shares one cache-line memory port between the instruction cache (read-only) and the data cache (read plus write-back).
- Sits between the two cache instances and the AXI bridge.
- Grants one read transaction at a time, using round-robin priority.
- Steers returned beats to the requester that owns the read and checks beat counts.
- Data-cache write-backs pass through to the memory port, gated by the memory's ready.

---
 rtl/cache_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port
// between the icache (reads) and the dcache (reads + write-backs).
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_rd_req,
  input  logic [2:0]                   i_rd_type,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic                         i_rd_rdy,
  output logic                         i_ret_valid,
  output logic                         i_ret_last,
  output logic [DATA_W-1:0]            i_ret_data,
  input  logic                         d_rd_req,
  input  logic [2:0]                   d_rd_type,
  input  logic [ADDR_W-1:0]            d_rd_addr,
  output logic                         d_rd_rdy,
  output logic                         d_ret_valid,
  output logic                         d_ret_last,
  output logic [DATA_W-1:0]            d_ret_data,
  input  logic                         d_wr_req,
  input  logic [2:0]                   d_wr_type,
  input  logic [ADDR_W-1:0]            d_wr_addr,
  input  logic [3:0]                   d_wr_wstrb,
  input  logic [LINE_BEATS*DATA_W-1:0] d_wr_data,
  output logic                         d_wr_rdy,
  output logic                         mem_rd_req,
  output logic [2:0]                   mem_rd_type,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic                         mem_rd_rdy,
  input  logic                         mem_ret_valid,
  input  logic                         mem_ret_last,
  input  logic [DATA_W-1:0]            mem_ret_data,
  output logic                         mem_wr_req,
  output logic [2:0]                   mem_wr_type,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [3:0]                   mem_wr_wstrb,
  output logic [LINE_BEATS*DATA_W-1:0] mem_wr_data,
  input  logic                         mem_wr_rdy,
  output logic                         owner,
  output logic                         beat_err
);

  localparam int CNT_W = $clog2(LINE_BEATS) + 1;
  localparam logic [2:0] T_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [2:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    exp_m1;
  logic                win;

  // Winner when both request: whoever was not granted last time.
  assign win = (i_rd_req && d_rd_req) ? ~last_q : d_rd_req;

  assign exp_m1 = (type_q == T_LINE) ? CNT_W'(LINE_BEATS - 1) : '0;

  assign mem_rd_type = type_q;
  assign mem_rd_addr = addr_q;
  assign owner       = owner_q;
  assign beat_err    = err_q;
  assign i_ret_data  = mem_ret_data;
  assign d_ret_data  = mem_ret_data;

  assign mem_wr_req   = d_wr_req;
  assign mem_wr_type  = d_wr_type;
  assign mem_wr_addr  = d_wr_addr;
  assign mem_wr_wstrb = d_wr_wstrb;
  assign mem_wr_data  = d_wr_data;
  assign d_wr_rdy     = mem_wr_rdy;

  // State and latched grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= R_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Arbitration, handshake steering and beat-count checking.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    type_d      = type_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_rd_req  = 1'b0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (mem_ret_valid) err_d = 1'b1;
        if (i_rd_req || d_rd_req) begin
          owner_d = win;
          last_d  = win;
          type_d  = win ? d_rd_type : i_rd_type;
          addr_d  = win ? d_rd_addr : i_rd_addr;
          state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (mem_ret_valid) err_d = 1'b1;
        mem_rd_req = 1'b1;
        i_rd_rdy   = ~owner_q & mem_rd_rdy;
        d_rd_rdy   = owner_q & mem_rd_rdy;
        if (mem_rd_rdy) begin
          state_d = R_RESP;
          cnt_d   = '0;
        end
      end
      R_RESP: begin
        i_ret_valid = ~owner_q & mem_ret_valid;
        i_ret_last  = ~owner_q & mem_ret_last;
        d_ret_valid = owner_q & mem_ret_valid;
        d_ret_last  = owner_q & mem_ret_last;
        if (mem_ret_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (mem_ret_last && cnt_q != exp_m1) err_d = 1'b1;
          if (!mem_ret_last && cnt_q == exp_m1) err_d = 1'b1;
          if (mem_ret_last) state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized and directed bench for cache_mem_arbiter
// against a transaction-level reference model.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic reset;
  logic i_rd_req, d_rd_req, d_wr_req;
  logic [2:0] i_rd_type, d_rd_type, d_wr_type;
  logic [AW-1:0] i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0] d_wr_wstrb;
  logic [LB*DW-1:0] d_wr_data;
  logic i_rd_rdy, i_ret_valid, i_ret_last;
  logic d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
  logic [DW-1:0] i_ret_data, d_ret_data;
  logic mem_rd_req, mem_rd_rdy;
  logic [2:0] mem_rd_type, mem_wr_type;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic mem_ret_valid, mem_ret_last;
  logic [DW-1:0] mem_ret_data;
  logic mem_wr_req, mem_wr_rdy;
  logic [3:0] mem_wr_wstrb;
  logic [LB*DW-1:0] mem_wr_data;
  logic owner, beat_err;

  int n_chk = 0;
  int n_pass = 0;
  bit m_last;
  bit m_err;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
    .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
    .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type),
    .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type),
    .mem_wr_addr(mem_wr_addr), .mem_wr_wstrb(mem_wr_wstrb),
    .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .owner(owner), .beat_err(beat_err)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0;
    d_wr_wstrb = 0; d_wr_data = 0;
    mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0;
    mem_ret_data = 0; mem_wr_rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    m_last = 0;
    m_err = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    #1;
    n_chk++;
    if ({mem_rd_req, i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_last,
         d_ret_valid, d_ret_last} !== 7'b0)
      $display("FAIL rst_ctl got %b%b%b%b%b%b%b exp 0", mem_rd_req,
               i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_last,
               d_ret_valid, d_ret_last);
    else n_pass++;
    cyc();
    cyc();
    reset = 0;
    m_last = 0;
    m_err = 0;
    #1;
    n_chk++;
    if ({owner, beat_err, mem_rd_req} !== 3'b0)
      $display("FAIL rst_state got own=%b err=%b req=%b exp 0",
               owner, beat_err, mem_rd_req);
    else n_pass++;
    n_chk++;
    if ({mem_rd_type, mem_rd_addr} !== '0)
      $display("FAIL rst_addr got t=%h a=%h exp 0", mem_rd_type,
               mem_rd_addr);
    else n_pass++;
  endtask

  task automatic test_icache_line();
    logic [DW-1:0] dat;
    do_reset();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C001000;
    #1;
    n_chk++;
    if (mem_rd_req !== 1'b0)
      $display("FAIL icl_req_early got %b exp 0", mem_rd_req);
    else n_pass++;
    cyc();
    #1;
    n_chk++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h1C001000 ||
        mem_rd_type !== 3'b100 || owner !== 1'b0)
      $display("FAIL icl_grant got req=%b a=%h t=%b own=%b exp 1/1c001000/100/0",
               mem_rd_req, mem_rd_addr, mem_rd_type, owner);
    else n_pass++;
    mem_rd_rdy = 1;
    #1;
    n_chk++;
    if (i_rd_rdy !== 1'b1 || d_rd_rdy !== 1'b0)
      $display("FAIL icl_rdy got i=%b d=%b exp 1/0", i_rd_rdy, d_rd_rdy);
    else n_pass++;
    cyc();
    i_rd_req = 0; mem_rd_rdy = 0;
    for (int b = 0; b < LB; b++) begin
      dat = DW'(32'hA0 + b);
      mem_ret_valid = 1; mem_ret_last = (b == LB - 1);
      mem_ret_data = dat;
      #1;
      n_chk++;
      if (i_ret_valid !== 1'b1 || i_ret_data !== dat ||
          i_ret_last !== (b == LB - 1) || d_ret_valid !== 1'b0)
        $display("FAIL icl_beat%0d got v=%b d=%h l=%b dv=%b exp 1/%h/%b/0",
                 b, i_ret_valid, i_ret_data, i_ret_last, d_ret_valid,
                 dat, b == LB - 1);
      else n_pass++;
      cyc();
    end
    mem_ret_valid = 0; mem_ret_last = 0;
    #1;
    n_chk++;
    if (beat_err !== 1'b0 || mem_rd_req !== 1'b0)
      $display("FAIL icl_end got err=%b req=%b exp 0/0", beat_err,
               mem_rd_req);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit win;
    logic [AW-1:0] a;
    logic exp_seq [3];
    exp_seq[0] = 1; exp_seq[1] = 0; exp_seq[2] = 1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1000 + r;
      d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h2000 + r;
      win = ~m_last;
      m_last = win;
      a = win ? d_rd_addr : i_rd_addr;
      cyc();
      #1;
      n_chk++;
      if (owner !== win || owner !== exp_seq[r] || mem_rd_addr !== a ||
          mem_rd_req !== 1'b1)
        $display("FAIL rr%0d_grant got own=%b a=%h exp %b/%h", r,
                 owner, mem_rd_addr, exp_seq[r], a);
      else n_pass++;
      mem_rd_rdy = 1;
      #1;
      n_chk++;
      if (d_rd_rdy !== win || i_rd_rdy !== ~win)
        $display("FAIL rr%0d_rdy got i=%b d=%b exp %b/%b", r, i_rd_rdy,
                 d_rd_rdy, ~win, win);
      else n_pass++;
      cyc();
      mem_rd_rdy = 0;
      if (win) d_rd_req = 0;
      else i_rd_req = 0;
      mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = DW'(r);
      #1;
      n_chk++;
      if (d_ret_valid !== win || i_ret_valid !== ~win)
        $display("FAIL rr%0d_ret got i=%b d=%b exp %b/%b", r,
                 i_ret_valid, d_ret_valid, ~win, win);
      else n_pass++;
      cyc();
      mem_ret_valid = 0; mem_ret_last = 0;
    end
    n_chk++;
    if (beat_err !== 1'b0)
      $display("FAIL rr_err got %b exp 0", beat_err);
    else n_pass++;
  endtask

  task automatic test_word_err();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h3000 + r;
      cyc();
      #1;
      n_chk++;
      if (mem_rd_req !== 1'b1 || owner !== 1'b1 || mem_rd_type !== 3'b010)
        $display("FAIL wd%0d_grant got req=%b own=%b t=%b exp 1/1/010",
                 r, mem_rd_req, owner, mem_rd_type);
      else n_pass++;
      mem_rd_rdy = 1;
      cyc();
      mem_rd_rdy = 0; d_rd_req = 0;
      mem_ret_valid = 1; mem_ret_last = (r == 0);
      cyc();
      mem_ret_valid = 0; mem_ret_last = 0;
      #1;
      n_chk++;
      if (beat_err !== (r == 1))
        $display("FAIL wd%0d_err got %b exp %b", r, beat_err, r == 1);
      else n_pass++;
      if (r == 0) begin
        n_chk++;
        if (mem_rd_req !== 1'b0)
          $display("FAIL wd0_idle got req=%b exp 0", mem_rd_req);
        else n_pass++;
      end
    end
    mem_ret_valid = 1; mem_ret_last = 1;
    #1;
    n_chk++;
    if (d_ret_valid !== 1'b1 || d_ret_last !== 1'b1)
      $display("FAIL wd_still_resp got v=%b l=%b exp 1/1", d_ret_valid,
               d_ret_last);
    else n_pass++;
    cyc();
    mem_ret_valid = 0; mem_ret_last = 0;
  endtask

  task automatic test_short_line();
    do_reset();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h4000;
    cyc();
    mem_rd_rdy = 1;
    cyc();
    mem_rd_rdy = 0; i_rd_req = 0;
    for (int b = 0; b < 3; b++) begin
      mem_ret_valid = 1; mem_ret_last = (b == 2);
      cyc();
    end
    mem_ret_valid = 0; mem_ret_last = 0;
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h5000;
    #1;
    n_chk++;
    if (beat_err !== 1'b1)
      $display("FAIL short_err got %b exp 1", beat_err);
    else n_pass++;
    cyc();
    #1;
    n_chk++;
    if (mem_rd_req !== 1'b1 || owner !== 1'b1 || mem_rd_addr !== 32'h5000)
      $display("FAIL short_idle got req=%b own=%b a=%h exp 1/1/5000",
               mem_rd_req, owner, mem_rd_addr);
    else n_pass++;
    d_rd_req = 0;
  endtask

  task automatic test_write();
    logic [AW-1:0] wa;
    logic [LB*DW-1:0] wd;
    logic [DW-1:0] dat;
    do_reset();
    wa = $urandom;
    wd = {$urandom, $urandom, $urandom, $urandom};
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h6000;
    cyc();
    mem_rd_rdy = 1;
    cyc();
    mem_rd_rdy = 0; i_rd_req = 0;
    for (int b = 0; b < LB; b++) begin
      d_wr_req = (b < 2); d_wr_type = 3'b100; d_wr_addr = wa;
      d_wr_data = wd; d_wr_wstrb = 4'hF;
      mem_wr_rdy = (b == 1);
      dat = $urandom;
      mem_ret_valid = 1; mem_ret_last = (b == LB - 1);
      mem_ret_data = dat;
      #1;
      n_chk++;
      if (d_wr_rdy !== (b == 1) || mem_wr_req !== (b < 2) ||
          mem_wr_addr !== wa || mem_wr_data !== wd ||
          mem_wr_wstrb !== 4'hF || mem_wr_type !== 3'b100)
        $display("FAIL wr%0d got rdy=%b req=%b a=%h exp %b/%b/%h", b,
                 d_wr_rdy, mem_wr_req, mem_wr_addr, b == 1, b < 2, wa);
      else n_pass++;
      n_chk++;
      if (i_ret_valid !== 1'b1 || i_ret_data !== dat ||
          i_ret_last !== (b == LB - 1))
        $display("FAIL wr%0d_beat got v=%b d=%h l=%b exp 1/%h/%b", b,
                 i_ret_valid, i_ret_data, i_ret_last, dat, b == LB - 1);
      else n_pass++;
      cyc();
    end
    idle_inputs();
    #1;
    n_chk++;
    if (beat_err !== 1'b0)
      $display("FAIL wr_err got %b exp 0", beat_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h7000;
    cyc();
    mem_rd_rdy = 1;
    cyc();
    mem_rd_rdy = 0; i_rd_req = 0;
    for (int b = 0; b < 2; b++) begin
      mem_ret_valid = 1; mem_ret_last = 0;
      cyc();
    end
    reset = 1;
    #1;
    n_chk++;
    if ({i_ret_valid, i_ret_last, mem_rd_req, owner, beat_err,
         i_rd_rdy, d_ret_valid} !== 7'b0)
      $display("FAIL rmid_out got v=%b l=%b req=%b own=%b err=%b exp 0",
               i_ret_valid, i_ret_last, mem_rd_req, owner, beat_err);
    else n_pass++;
    cyc();
    mem_ret_valid = 0;
    cyc();
    reset = 0;
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h7100;
    cyc();
    #1;
    n_chk++;
    if (mem_rd_req !== 1'b1 || owner !== 1'b1 || mem_rd_addr !== 32'h7100)
      $display("FAIL rmid_grant got req=%b own=%b a=%h exp 1/1/7100",
               mem_rd_req, owner, mem_rd_addr);
    else n_pass++;
    mem_rd_rdy = 1;
    cyc();
    mem_rd_rdy = 0; d_rd_req = 0;
    mem_ret_valid = 1; mem_ret_last = 1;
    cyc();
    mem_ret_valid = 0; mem_ret_last = 0;
    #1;
    n_chk++;
    if (beat_err !== 1'b0 || mem_rd_req !== 1'b0)
      $display("FAIL rmid_end got err=%b req=%b exp 0/0", beat_err,
               mem_rd_req);
    else n_pass++;
  endtask

  task automatic test_random();
    bit pi, pd, win;
    logic [2:0] ti, td, t;
    logic [AW-1:0] ai, ad, a;
    logic [DW-1:0] dat;
    int exp_n, n_b, wait_c;
    do_reset();
    pi = 0; pd = 0; ti = 0; td = 0; ai = 0; ad = 0;
    for (int k = 0; k < 40; k++) begin
      if (!pi && $urandom_range(1, 0) == 1) begin
        pi = 1; ai = $urandom;
        ti = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'($urandom_range(2, 0));
      end
      if (!pd && $urandom_range(1, 0) == 1) begin
        pd = 1; ad = $urandom;
        td = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'($urandom_range(2, 0));
      end
      if (!pi && !pd) begin
        pi = 1; ti = 3'b010; ai = $urandom;
      end
      i_rd_req = pi; i_rd_type = ti; i_rd_addr = ai;
      d_rd_req = pd; d_rd_type = td; d_rd_addr = ad;
      win = (pi && pd) ? ~m_last : pd;
      m_last = win;
      t = win ? td : ti;
      a = win ? ad : ai;
      cyc();
      #1;
      n_chk++;
      if (mem_rd_req !== 1'b1 || owner !== win || mem_rd_addr !== a ||
          mem_rd_type !== t)
        $display("FAIL rnd%0d_grant got req=%b own=%b a=%h t=%b exp 1/%b/%h/%b",
                 k, mem_rd_req, owner, mem_rd_addr, mem_rd_type, win, a, t);
      else n_pass++;
      wait_c = $urandom_range(2, 0);
      for (int w = 0; w < wait_c; w++) begin
        n_chk++;
        if (i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0)
          $display("FAIL rnd%0d_wait got i=%b d=%b exp 0/0", k, i_rd_rdy,
                   d_rd_rdy);
        else n_pass++;
        cyc();
        #1;
      end
      mem_rd_rdy = 1;
      #1;
      n_chk++;
      if (d_rd_rdy !== win || i_rd_rdy !== ~win)
        $display("FAIL rnd%0d_rdy got i=%b d=%b exp %b/%b", k, i_rd_rdy,
                 d_rd_rdy, ~win, win);
      else n_pass++;
      cyc();
      mem_rd_rdy = 0;
      if (win) pd = 0;
      else pi = 0;
      i_rd_req = pi; d_rd_req = pd;
      exp_n = (t == 3'b100) ? LB : 1;
      n_b = exp_n;
      if (exp_n > 1 && $urandom_range(7, 0) == 0)
        n_b = $urandom_range(exp_n - 1, 1);
      if (n_b != exp_n) m_err = 1;
      for (int b = 0; b < n_b; b++) begin
        if ($urandom_range(3, 0) == 0) begin
          mem_ret_valid = 0;
          #1;
          n_chk++;
          if (i_ret_valid !== 1'b0 || d_ret_valid !== 1'b0)
            $display("FAIL rnd%0d_gap got i=%b d=%b exp 0/0", k,
                     i_ret_valid, d_ret_valid);
          else n_pass++;
          cyc();
        end
        dat = $urandom;
        mem_ret_valid = 1; mem_ret_last = (b == n_b - 1);
        mem_ret_data = dat;
        #1;
        n_chk++;
        if ((win ? d_ret_valid : i_ret_valid) !== 1'b1 ||
            (win ? i_ret_valid : d_ret_valid) !== 1'b0 ||
            (win ? d_ret_last : i_ret_last) !== (b == n_b - 1) ||
            (win ? d_ret_data : i_ret_data) !== dat)
          $display("FAIL rnd%0d_beat%0d got iv=%b dv=%b il=%b dl=%b exp own=%b last=%b",
                   k, b, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
                   win, b == n_b - 1);
        else n_pass++;
        cyc();
      end
      mem_ret_valid = 0; mem_ret_last = 0;
      #1;
      n_chk++;
      if (beat_err !== m_err || mem_rd_req !== 1'b0)
        $display("FAIL rnd%0d_end got err=%b req=%b exp %b/0", k, beat_err,
                 mem_rd_req, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_icache_line();
    test_round_robin();
    test_word_err();
    test_short_line();
    test_write();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
